// File: rtl/more_procedural_sink_if.sv
// Handshake bundle between the ALU stage, the result buffer and its consumer.
// master drives results in and accepts them out; slave is the buffer.
interface more_procedural_sink_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_mode;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_acc;
    logic [CW-1:0]     count;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data,
        input  out_acc, count
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data,
        output out_acc, count
    );
endinterface

// File: rtl/more_procedural_sink.sv
// Registered FIFO buffer for ALU results with a wrapping sum of popped data.
// Define MORE_PROC_SINK_STATS_EN to add saturating per-mode pop counters.
module more_procedural_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    more_procedural_sink_if.slave bus
`ifdef MORE_PROC_SINK_STATS_EN
    ,
    input  logic [1:0]  stat_sel,
    output logic [15:0] stat_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]        mode_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              push, pop;

    // Ready/valid come only from registered occupancy.
    assign bus.in_ready  = (count_q < CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_mode  = mode_mem[rd_ptr_q];
    assign bus.out_data  = data_mem[rd_ptr_q];
    assign bus.out_acc   = acc_q;
    assign bus.count     = count_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            acc_d    = acc_q + bus.out_data;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mode_mem[wr_ptr_q] <= bus.in_mode;
            data_mem[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef MORE_PROC_SINK_STATS_EN
    logic [15:0] stat_q [4];

    assign stat_cnt = stat_q[stat_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else if (pop && stat_q[bus.out_mode] != 16'hFFFF) begin
            stat_q[bus.out_mode] <= stat_q[bus.out_mode] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_more_procedural_sink.sv
// Self-checking bench for more_procedural_sink: vector table plus
// scoreboard queue, with hand sequences for wrap and async reset.
module tb_more_procedural_sink;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        bit          v;
        logic [1:0]  m;
        logic [31:0] d;
        bit          r;
        int          ecnt;
        logic [31:0] eacc;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ent_t        mq[$];
    logic [31:0] acc_m;
    int          st_m[4];

    more_procedural_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef MORE_PROC_SINK_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;

    more_procedural_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );
`else
    more_procedural_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        acc_m = '0;
        for (int i = 0; i < 4; i++) st_m[i] = 0;
    endtask

    // Check current outputs against the model, then apply one edge.
    task automatic cyc(input bit v, input logic [1:0] m,
                       input logic [31:0] d, input bit r);
        bit   pu, po;
        ent_t e;
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.out_ready = r;
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("out_acc", bus.out_acc, acc_m);
        if (mq.size() != 0) begin
            chk("out_data", bus.out_data, mq[0].d);
            chk("out_mode", 32'(bus.out_mode), 32'(mq[0].m));
        end
        pu = v && (mq.size() < DEPTH);
        po = r && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (po) begin
            e = mq.pop_front();
            acc_m = acc_m + e.d;
            if (st_m[e.m] < 65535) st_m[e.m]++;
        end
        if (pu) mq.push_back('{m: m, d: d});
    endtask

    vec_t vt[12];

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef MORE_PROC_SINK_STATS_EN
        stat_sel = '0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_acc", bus.out_acc, 32'd0);

        vt[0]  = '{1, 2'd0, 32'h6, 0, 0, 32'd0};
        vt[1]  = '{0, 2'd0, 32'h0, 1, 1, 32'd0};
        vt[2]  = '{1, 2'd1, 32'h1, 0, 0, 32'd6};
        vt[3]  = '{1, 2'd2, 32'h2, 0, 1, 32'd6};
        vt[4]  = '{1, 2'd3, 32'h3, 0, 2, 32'd6};
        vt[5]  = '{1, 2'd0, 32'h4, 0, 3, 32'd6};
        vt[6]  = '{1, 2'd1, 32'h5, 0, 4, 32'd6};
        vt[7]  = '{0, 2'd0, 32'h0, 1, 4, 32'd6};
        vt[8]  = '{0, 2'd0, 32'h0, 1, 3, 32'd7};
        vt[9]  = '{0, 2'd0, 32'h0, 1, 2, 32'd9};
        vt[10] = '{0, 2'd0, 32'h0, 1, 1, 32'd12};
        vt[11] = '{0, 2'd0, 32'h0, 0, 0, 32'd16};

        foreach (vt[i]) begin
            chk("vec_count", 32'(bus.count), 32'(vt[i].ecnt));
            chk("vec_acc", bus.out_acc, vt[i].eacc);
            cyc(vt[i].v, vt[i].m, vt[i].d, vt[i].r);
        end
        chk("full_dropped", 32'(mq.size()), 32'd0);

        // Wrapping sum under sustained push/pop at count 1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1, 2'd2, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 2'd2, 32'hFFFF_FFFF, 1);
            chk("stream_count", 32'(bus.count), 32'd1);
        end
        chk("wrap_acc", bus.out_acc, 32'hFFFF_FFF6);
        cyc(0, 2'd0, 32'h0, 1);
        chk("wrap_acc2", bus.out_acc, 32'hFFFF_FFF5);

        // Asynchronous reset with three entries queued.
        cyc(1, 2'd1, 32'hA1, 0);
        cyc(1, 2'd1, 32'hA2, 0);
        cyc(1, 2'd1, 32'hA3, 0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_acc", bus.out_acc, 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 2'd3, 32'h55, 0);
        chk("post_rst_data", bus.out_data, 32'h55);
        cyc(0, 2'd0, 32'h0, 1);
        cyc(0, 2'd0, 32'h0, 0);

`ifdef MORE_PROC_SINK_STATS_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1, 2'd0, 32'h1, 0);
        cyc(1, 2'd1, 32'h2, 1);
        cyc(1, 2'd1, 32'h3, 1);
        cyc(1, 2'd3, 32'h4, 1);
        cyc(0, 2'd0, 32'h0, 1);
        cyc(0, 2'd0, 32'h0, 0);
        stat_sel = 2'd1;
        #1;
        chk("stat_mode1", 32'(stat_cnt), 32'd2);
        stat_sel = 2'd2;
        #1;
        chk("stat_mode2", 32'(stat_cnt), 32'd0);
        stat_sel = 2'd3;
        for (int i = 0; i < 65536; i++) cyc(1, 2'd3, 32'h1, 1);
        cyc(0, 2'd0, 32'h0, 1);
        chk("stat_sat", 32'(stat_cnt), 32'(st_m[3]));
        chk("stat_sat_ffff", 32'(stat_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
